// File: rtl/call_ret_ctrl.sv
// Return-address stack initiator: pushes on CALL, pops on RET, redirects fetch.
// Define CALL_RET_HWM_EN to add the hwm high-water-mark output.
module call_ret_ctrl #(
  parameter int AW     = 32,
  parameter int DEPTH  = 31,
  parameter int PC_INC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] call_target,
  output logic          stk_write,
  output logic          stk_read,
  output logic [AW-1:0] stk_wdata,
  input  logic [AW-1:0] stk_rdata,
  output logic          redir_valid,
  output logic [AW-1:0] redir_pc,
  output logic          busy,
  output logic [5:0]    depth,
  output logic          ovf_err,
  output logic          unf_err
`ifdef CALL_RET_HWM_EN
  ,
  output logic [5:0]    hwm
`endif
);

  typedef enum logic [2:0] {
    IDLE, PUSH, POP, CAPT, REDIR
  } state_t;

  state_t        state, state_d;
  logic          write_d, read_d, rv_d;
  logic          ovf_d, unf_d, busy_d;
  logic [AW-1:0] wdata_d, pc_d;
  logic [5:0]    depth_d;

  always_comb begin
    state_d = state;
    write_d = 1'b0;
    read_d  = 1'b0;
    rv_d    = 1'b0;
    wdata_d = stk_wdata;
    pc_d    = redir_pc;
    depth_d = depth;
    ovf_d   = ovf_err;
    unf_d   = unf_err;
    unique case (state)
      IDLE: begin
        // CALL has priority; a simultaneous RET is dropped
        if (call_req) begin
          if (depth < 6'(DEPTH)) begin
            state_d = PUSH;
            write_d = 1'b1;
            wdata_d = pc_in + AW'(PC_INC);
            pc_d    = call_target;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ret_req) begin
          if (depth != 6'd0) begin
            state_d = POP;
            read_d  = 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      PUSH: begin
        depth_d = depth + 6'd1;
        state_d = REDIR;
        rv_d    = 1'b1;
      end
      POP: begin
        depth_d = depth - 6'd1;
        state_d = CAPT;
      end
      CAPT: begin
        pc_d    = stk_rdata;
        state_d = REDIR;
        rv_d    = 1'b1;
      end
      REDIR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stk_write   <= 1'b0;
      stk_read    <= 1'b0;
      stk_wdata   <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      busy        <= 1'b0;
      depth       <= 6'd0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
    end else begin
      state       <= state_d;
      stk_write   <= write_d;
      stk_read    <= read_d;
      stk_wdata   <= wdata_d;
      redir_valid <= rv_d;
      redir_pc    <= pc_d;
      busy        <= busy_d;
      depth       <= depth_d;
      ovf_err     <= ovf_d;
      unf_err     <= unf_d;
    end
  end

`ifdef CALL_RET_HWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm <= 6'd0;
    end else if (depth_d > hwm) begin
      hwm <= depth_d;
    end
  end
`endif

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Scoreboard bench for call_ret_ctrl with a behavioural return-address stack.
// Expected stack traffic and redirects are queued by stimulus, checked by a monitor.
module tb_call_ret_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        call_req, ret_req;
  logic [31:0] pc_in, call_target;
  logic        stk_write, stk_read;
  logic [31:0] stk_wdata, stk_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        busy;
  logic [5:0]  depth;
  logic        ovf_err, unf_err;
`ifdef CALL_RET_HWM_EN
  logic [5:0]  hwm;
`endif

  call_ret_ctrl dut (
    .clk(clk), .rst(rst),
    .call_req(call_req), .ret_req(ret_req),
    .pc_in(pc_in), .call_target(call_target),
    .stk_write(stk_write), .stk_read(stk_read),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .busy(busy), .depth(depth),
    .ovf_err(ovf_err), .unf_err(unf_err)
`ifdef CALL_RET_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural 32-entry stack, reset together with the controller
  logic [31:0] mem [32];
  int          top;
  always @(posedge clk) begin
    if (rst) begin
      top       <= 0;
      stk_rdata <= '0;
    end else if (stk_write && top < 31) begin
      mem[top] <= stk_wdata;
      top      <= top + 1;
    end else if (stk_read && top > 0) begin
      stk_rdata <= mem[top-1];
      top       <= top - 1;
    end
  end

  typedef struct {
    logic [31:0] v;
    int          c;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t vq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: every DUT stack access or redirect must match a queued event
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (stk_write && stk_read) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_rd_overlap at cycle %0d", cyc);
      end
      if (stk_write) begin
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write data 0x%0h cycle %0d", stk_wdata, cyc);
        end else begin
          e = wq.pop_front();
          check("wdata", stk_wdata, e.v);
          check("write_cycle", cyc, e.c);
        end
      end
      if (stk_read) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_read cycle %0d", cyc);
        end else begin
          e = rq.pop_front();
          check("read_cycle", cyc, e.c);
        end
      end
      if (redir_valid) begin
        if (vq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_redir pc 0x%0h cycle %0d", redir_pc, cyc);
        end else begin
          e = vq.pop_front();
          check("redir_pc", redir_pc, e.v);
          check("redir_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL busy_timeout at cycle %0d", cyc);
  endtask

  task automatic do_call(input logic [31:0] pc, input logic [31:0] tgt,
                         input bit ok, input bit with_ret);
    wait_idle();
    call_req    = 1'b1;
    ret_req     = with_ret;
    pc_in       = pc;
    call_target = tgt;
    if (ok) begin
      wq.push_back('{pc + 32'd1, cyc + 1});
      vq.push_back('{tgt, cyc + 2});
    end
    @(posedge clk);
    #1;
    call_req = 1'b0;
    ret_req  = 1'b0;
  endtask

  task automatic do_ret(input logic [31:0] exp, input bit ok);
    wait_idle();
    ret_req = 1'b1;
    if (ok) begin
      rq.push_back('{32'd0, cyc + 1});
      vq.push_back('{exp, cyc + 3});
    end
    @(posedge clk);
    #1;
    ret_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    call_req    = 1'b0;
    ret_req     = 1'b0;
    pc_in       = '0;
    call_target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_stk_write", stk_write, 0);
    check("rst_stk_read", stk_read, 0);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_redir_pc", redir_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_depth", depth, 0);
    check("rst_errs", {ovf_err, unf_err}, 0);
`ifdef CALL_RET_HWM_EN
    check("rst_hwm", hwm, 0);
`endif

    do_call(32'h100, 32'h400, 1, 0);
    wait_idle();
    check("depth_after_call", depth, 1);
    do_ret(32'h101, 1);
    wait_idle();
    check("depth_after_ret", depth, 0);
    check("errs_after_ret", {ovf_err, unf_err}, 0);

    // nested calls fill the stack to its usable depth
    for (int i = 0; i < 31; i++)
      do_call(32'(i), 32'h1000 + 32'(i), 1, 0);
    wait_idle();
    check("depth_full", depth, 31);
`ifdef CALL_RET_HWM_EN
    check("hwm_full", hwm, 31);
`endif
    do_call(32'h55, 32'h66, 0, 0);
    wait_idle();
    check("ovf_err", ovf_err, 1);
    check("depth_after_ovf", depth, 31);
    for (int i = 0; i < 31; i++)
      do_ret(32'(31 - i), 1);
    wait_idle();
    check("depth_drained", depth, 0);
    check("ovf_sticky", ovf_err, 1);

    do_reset();
    check("ovf_cleared", ovf_err, 0);
`ifdef CALL_RET_HWM_EN
    check("hwm_cleared", hwm, 0);
`endif
    do_ret(32'h0, 0);
    wait_idle();
    check("unf_err", unf_err, 1);
    check("depth_after_unf", depth, 0);
    do_call(32'h200, 32'h800, 1, 0);
    wait_idle();
    check("unf_sticky", unf_err, 1);
    check("depth_after_unf_call", depth, 1);
    do_call(32'h210, 32'h810, 1, 0);
    do_call(32'h220, 32'h820, 1, 1);
    wait_idle();
    check("depth_call_wins", depth, 3);

    // reset while the POP is in flight cancels the redirect
    wait_idle();
    ret_req = 1'b1;
    rq.push_back('{32'd0, cyc + 1});
    @(posedge clk);
    #1;
    ret_req = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midpop_busy", busy, 0);
    check("midpop_depth", depth, 0);
    check("midpop_errs", {ovf_err, unf_err}, 0);
    check("midpop_redir", redir_valid, 0);
    repeat (8) @(negedge clk);
    check("midpop_no_redir", redir_valid, 0);
    check("pending_events", wq.size() + rq.size() + vq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
